rv_wb_arbiter: RTL
==================

RV_WB_ARBITER -- requirements
Module: rv_wb_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester channels, 2..8.
REQ-002 Parameter PRIORITY_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: BUS-state cycles without response before abort (used only with RV_WB_TIMEOUT_EN).
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 i_clk  in  1  clock, all state updates on rising edge.
REQ-006 i_reset_n  in  1  synchronous active-low reset.
REQ-007 i_req  in  NUM_PORTS  per-port request; held until that port's o_ack or o_err.
REQ-008 i_we  in  NUM_PORTS  per-port write enable.
REQ-009 i_addr  in  NUM_PORTS x 32  per-port byte address.
REQ-010 i_wdata  in  NUM_PORTS x 32  per-port write data.
REQ-011 i_sel  in  NUM_PORTS x 4  per-port byte select.
REQ-012 o_ack  out  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-013 o_err  out  NUM_PORTS  one-cycle error pulse to the granted port.
REQ-014 o_rdata  out  32  read data, valid in the o_ack cycle.
REQ-015 o_wb_adr/o_wb_dat/o_wb_sel/o_wb_we  out  32/32/4/1  Wishbone classic master fields.
REQ-016 o_wb_cyc, o_wb_stb  out  1 each  Wishbone cycle/strobe.
REQ-017 i_wb_dat/i_wb_ack/i_wb_err  in  32/1/1  Wishbone slave response.
REQ-018 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, BUS, RESP; IDLE->BUS when any i_req high; BUS->RESP on i_wb_ack or i_wb_err (or timeout); RESP->IDLE unconditionally.
REQ-020 On IDLE->BUS edge the arbiter latches the winner index and its addr/wdata/we/sel into registers; Wishbone outputs drive only from these registers.
REQ-021 o_wb_cyc and o_wb_stb are 1 exactly in BUS; fields stay constant throughout BUS.
REQ-022 On ack edge i_wb_dat is registered into o_rdata; o_ack[grant] is 1 for exactly the RESP cycle.
REQ-023 i_wb_ack and i_wb_err together in one cycle: error wins, o_err pulses, o_ack stays 0.
REQ-024 Latency: req seen in cycle 0, cyc/stb in cycle 1, slave ack in cycle k >= 1, o_ack in cycle k+1; minimum 3 cycles per transaction.
REQ-025 Requester dropping i_req during BUS/RESP is ignored: transaction completes, pulse still issued.
REQ-026 Fixed mode: lowest-index requesting port wins each IDLE arbitration.
REQ-027 Round-robin: search starts at last_grant+1 modulo NUM_PORTS; last_grant updates only on grant.
REQ-028 Ack/err arriving outside BUS is ignored.

Reset
REQ-029 Reset: state IDLE, o_wb_cyc/o_wb_stb/o_wb_we 0, o_wb_sel 0, o_ack/o_err 0, o_rdata 0, o_busy 0, last_grant NUM_PORTS-1 (port 0 first in round-robin).
REQ-030 Reset during BUS drops cyc/stb at that edge; no o_ack/o_err is issued for the aborted transaction.

Configuration
REQ-031 Macro RV_WB_TIMEOUT_EN defined: counter clears on BUS entry, increments each BUS cycle; reaching TIMEOUT_CYCLES forces BUS->RESP with o_err, o_rdata 0.
REQ-032 Macro undefined: no counter logic, BUS waits indefinitely, TIMEOUT_CYCLES unused.

Structure
REQ-033 Package rv_wb_pkg holds the FSM state enum and PRIORITY_MODE constants (PRIO_FIXED=0, PRIO_RR=1).
REQ-034 Sub-module rv_wb_rr_arbiter computes combinational grant index from i_req, last_grant and mode.

Verification
REQ-035 Port0 read 0x100, slave acks 2 cycles after cyc with 0xDEADBEEF -> o_ack[0] one cycle, o_rdata 0xDEADBEEF, cyc low after.
REQ-036 Fixed mode, ports 0 and 1 request together continuously -> port 0 granted every transaction, port 1 starved.
REQ-037 Round-robin, NUM_PORTS=3, all request continuously -> grant order 0,1,2,0,1,2.
REQ-038 Port1 write 0x200 data 0x12345678 sel 0x3 with ack+err same cycle -> o_err[1] pulse, o_ack[1] stays 0.
REQ-039 RV_WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave silent -> o_err pulse after 4 BUS cycles, o_rdata 0.
REQ-040 Reset asserted in 2nd BUS cycle -> next cycle cyc/stb 0, state IDLE, no ack/err pulse.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared types for the Wishbone request arbiter: FSM encoding and
// arbitration-mode constants.
package rv_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

endpackage

// File: rtl/rv_wb_arbiter_if.sv
// Wishbone classic master bus between the arbiter and a single slave.
interface rv_wb_arbiter_if;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport master (
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    input  i_wb_dat, i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    output i_wb_dat, i_wb_ack, i_wb_err
  );
endinterface

// File: rtl/rv_wb_rr_arbiter.sv
// Combinational grant selection. The search starts at port 0 in fixed
// mode and at last_grant+1 (wrapping) in round-robin mode; the first
// requesting port found wins.
module rv_wb_rr_arbiter
  import rv_wb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MODE      = PRIO_FIXED,
  localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_grant,
  output logic [IDX_W-1:0]     o_grant,
  output logic                 o_valid
);

  // Scan all ports once from the mode-dependent start index.
  always_comb begin : p_search
    int start;
    int idx;
    o_grant = '0;
    o_valid = 1'b0;
    start   = (MODE == PRIO_RR) ? ((int'(i_last_grant) + 1) % NUM_PORTS) : 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (start + k) % NUM_PORTS;
      if (!o_valid && i_req[IDX_W'(idx)]) begin
        o_valid = 1'b1;
        o_grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// N-port to one Wishbone classic master arbiter. IDLE picks a winner and
// latches its request, BUS holds cyc/stb until the slave answers, RESP
// returns a one-cycle ack or err pulse to the granted port.
// Optional macro RV_WB_TIMEOUT_EN aborts a BUS phase after TIMEOUT_CYCLES
// cycles with an error response and zero read data.
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int PRIORITY_MODE  = PRIO_FIXED,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_PORTS-1:0]      i_req,
  input  logic [NUM_PORTS-1:0]      i_we,
  input  logic [NUM_PORTS-1:0][31:0] i_addr,
  input  logic [NUM_PORTS-1:0][31:0] i_wdata,
  input  logic [NUM_PORTS-1:0][3:0]  i_sel,
  output logic [NUM_PORTS-1:0]      o_ack,
  output logic [NUM_PORTS-1:0]      o_err,
  output logic [31:0]               o_rdata,
  output logic                      o_busy,
  rv_wb_arbiter_if.master           wb
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] arb_grant;
  logic             arb_valid;
  logic             timeout;

  rv_wb_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .MODE      (PRIORITY_MODE)
  ) u_arb (
    .i_req        (i_req),
    .i_last_grant (last_q),
    .o_grant      (arb_grant),
    .o_valid      (arb_valid)
  );

`ifdef RV_WB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Count BUS cycles; the count is held at zero outside BUS.
  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (state_q == ST_BUS) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      timeout  = (to_cnt_d == TO_W'(TIMEOUT_CYCLES));
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) to_cnt_q <= '0;
    else            to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
  // TIMEOUT_CYCLES has no effect in this build.
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  // Next-state, request capture and response capture.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_BUS;
          grant_d = arb_grant;
          last_d  = arb_grant;
          adr_d   = i_addr[arb_grant];
          dat_d   = i_wdata[arb_grant];
          sel_d   = i_sel[arb_grant];
          we_d    = i_we[arb_grant];
        end
      end
      ST_BUS: begin
        // Error (slave or timeout) takes precedence over a coincident ack.
        if (wb.i_wb_err || timeout) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (wb.i_wb_ack) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = wb.i_wb_dat;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Completion pulse decode for the granted port during RESP.
  always_comb begin
    o_ack = '0;
    o_err = '0;
    if (state_q == ST_RESP) begin
      if (err_q) o_err[grant_q] = 1'b1;
      else       o_ack[grant_q] = 1'b1;
    end
  end

  assign wb.o_wb_adr = adr_q;
  assign wb.o_wb_dat = dat_q;
  assign wb.o_wb_sel = sel_q;
  assign wb.o_wb_we  = we_q;
  assign wb.o_wb_cyc = (state_q == ST_BUS);
  assign wb.o_wb_stb = (state_q == ST_BUS);
  assign o_rdata     = rdata_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule
